hazard_ctrl: RTL

Pipeline hazard controller that drives the `en` and `no_output` controls of the IF/ID and ID/EX pipeline registers. It sits beside the ID stage and compares decode-stage source registers against the instruction held in ID/EX. From that it decides, each cycle, whether to advance, stall or bubble, and it handles taken-branch flushes and multi-cycle-unit stalls. It also keeps stall and flush performance counters.

---
 rtl/hazard_ctrl_pkg.sv | 53 +++++
 rtl/hazard_ctrl_if.sv | 46 ++++
 rtl/hazard_ctrl_perf_cnt.sv | 47 ++++
 rtl/hazard_ctrl.sv | 107 ++++++++++
 4 files changed

// File: rtl/hazard_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// pipeline_pkg
// Shared pipeline definitions used by the hazard controller and its neighbours:
//   - register index width
//   - hazard FSM state encoding (2-bit, legacy-compatible localparams)
//   - ALU command codes carried in ID/EX (ALU_command_out)
//   - is_load() helper used by the ID/EX side to produce ex_is_load
//   - packed bundle of the five pipeline control strobes
// -----------------------------------------------------------------------------
package pipeline_pkg;

  localparam int REG_IDX_W = 5;

  // Hazard FSM encoding; also exported on state_o for debug.
  localparam logic [1:0] ST_RUN    = 2'd0;
  localparam logic [1:0] ST_LSTALL = 2'd1;
  localparam logic [1:0] ST_FLUSH  = 2'd2;
  localparam logic [1:0] ST_BUSY   = 2'd3;

  typedef enum logic [3:0] {
    ALU_ADD = 4'd0,
    ALU_SUB = 4'd1,
    ALU_AND = 4'd2,
    ALU_OR  = 4'd3,
    ALU_XOR = 4'd4,
    ALU_SLT = 4'd5,
    ALU_SLL = 4'd6,
    ALU_SRL = 4'd7,
    ALU_LW  = 4'd8,
    ALU_LH  = 4'd9,
    ALU_LB  = 4'd10,
    ALU_SW  = 4'd11,
    ALU_BEQ = 4'd12,
    ALU_JAL = 4'd13,
    ALU_MUL = 4'd14,
    ALU_DIV = 4'd15
  } alu_cmd_e;

  // True for commands whose result is only available after the memory stage.
  function automatic logic is_load(input alu_cmd_e cmd);
    return (cmd == ALU_LW) || (cmd == ALU_LH) || (cmd == ALU_LB);
  endfunction

  // Control strobes for PC, IF/ID and ID/EX. no_output fields are active-low.
  typedef struct packed {
    logic pc_en;
    logic if_id_en;
    logic if_id_no_output;
    logic id_ex_en;
    logic id_ex_no_output;
  } hz_ctrl_t;

endpackage

// File: rtl/hazard_ctrl_if.sv
// -----------------------------------------------------------------------------
// hazard_ctrl_if
// Bundles the hazard controller's decode/execute observation signals and its
// pipeline control outputs.
//   master : pipeline side (drives operands/events, receives controls)
//   slave  : hazard controller side
// -----------------------------------------------------------------------------
interface hazard_ctrl_if #(
  parameter int CNT_W   = 32,
  parameter int FLUSH_W = 16
);
  import pipeline_pkg::*;

  logic [REG_IDX_W-1:0] id_r1;
  logic [REG_IDX_W-1:0] id_r2;
  logic                 id_uses_r1;
  logic                 id_uses_r2;
  logic [REG_IDX_W-1:0] ex_rd;
  logic                 ex_is_load;
  logic                 ex_branch_taken;
  logic                 mdu_busy;

  logic                 pc_en;
  logic                 if_id_en;
  logic                 if_id_no_output;
  logic                 id_ex_en;
  logic                 id_ex_no_output;
  logic [1:0]           state_o;
  logic [CNT_W-1:0]     stall_cycles;
  logic [FLUSH_W-1:0]   flush_count;

  modport master (
    output id_r1, id_r2, id_uses_r1, id_uses_r2, ex_rd, ex_is_load,
           ex_branch_taken, mdu_busy,
    input  pc_en, if_id_en, if_id_no_output, id_ex_en, id_ex_no_output,
           state_o, stall_cycles, flush_count
  );

  modport slave (
    input  id_r1, id_r2, id_uses_r1, id_uses_r2, ex_rd, ex_is_load,
           ex_branch_taken, mdu_busy,
    output pc_en, if_id_en, if_id_no_output, id_ex_en, id_ex_no_output,
           state_o, stall_cycles, flush_count
  );

endinterface

// File: rtl/hazard_ctrl_perf_cnt.sv
// -----------------------------------------------------------------------------
// hazard_perf_cnt
// Performance counters for the hazard controller.
//   clk, rst        : core clock, asynchronous active-low reset
//   stall_i         : this cycle has pc_en=0
//   flush_i         : this cycle is a taken-branch flush
//   stall_cycles_o  : saturating count of stall cycles
//   flush_count_o   : wrapping count of flushes
// -----------------------------------------------------------------------------
module hazard_perf_cnt #(
  parameter int CNT_W   = 32,
  parameter int FLUSH_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall_i,
  input  logic               flush_i,
  output logic [CNT_W-1:0]   stall_cycles_o,
  output logic [FLUSH_W-1:0] flush_count_o
);

  logic [CNT_W-1:0]   stall_q, stall_d;
  logic [FLUSH_W-1:0] flush_q, flush_d;

  always_comb begin
    stall_d = stall_q;
    flush_d = flush_q;
    // Stall counter sticks at all-ones instead of rolling back to zero.
    if (stall_i && (stall_q != '1)) stall_d = stall_q + 1'b1;
    // Flush counter wraps naturally at 2^FLUSH_W.
    if (flush_i) flush_d = flush_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end

  assign stall_cycles_o = stall_q;
  assign flush_count_o  = flush_q;

endmodule

// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
// Pipeline hazard controller beside the ID stage. Each cycle it decides
// whether the front end advances, stalls for a load-use dependency, freezes
// while the multi-cycle unit is busy, or squashes IF/ID and ID/EX after a
// taken branch. Priority: flush > busy > load-use > run.
//   clk, rst                 : core clock, asynchronous active-low reset
//   id_r1/id_r2, id_uses_r*  : decode-stage source operands
//   ex_rd, ex_is_load        : destination and load flag held in ID/EX
//   ex_branch_taken          : EX resolved a taken branch/jump this cycle
//   mdu_busy                 : mul/div unit occupied
//   pc_en, *_en, *_no_output : pipeline controls (no_output active-low)
//   state_o                  : FSM state for debug
//   stall_cycles/flush_count : performance counters
// -----------------------------------------------------------------------------
module hazard_ctrl
  import pipeline_pkg::*;
#(
  parameter int CNT_W   = 32,
  parameter int FLUSH_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [REG_IDX_W-1:0] id_r1,
  input  logic [REG_IDX_W-1:0] id_r2,
  input  logic                 id_uses_r1,
  input  logic                 id_uses_r2,
  input  logic [REG_IDX_W-1:0] ex_rd,
  input  logic                 ex_is_load,
  input  logic                 ex_branch_taken,
  input  logic                 mdu_busy,
  output logic                 pc_en,
  output logic                 if_id_en,
  output logic                 if_id_no_output,
  output logic                 id_ex_en,
  output logic                 id_ex_no_output,
  output logic [1:0]           state_o,
  output logic [CNT_W-1:0]     stall_cycles,
  output logic [FLUSH_W-1:0]   flush_count
);

  logic [1:0] state_q, state_d;
  hz_ctrl_t   ctrl;
  logic       lu_hit;

  // x0 never carries a real dependency; unused operands are ignored.
  assign lu_hit = ex_is_load && (ex_rd != '0) &&
                  ((id_uses_r1 && (id_r1 == ex_rd)) ||
                   (id_uses_r2 && (id_r2 == ex_rd)));

  always_comb begin
    // NOTE: every output of this block gets a default before the priority
    // chain, so no path leaves a value unassigned and no latch is inferred.
    ctrl    = '{pc_en: 1'b1, if_id_en: 1'b1, if_id_no_output: 1'b1,
                id_ex_en: 1'b1, id_ex_no_output: 1'b1};
    state_d = ST_RUN;

    if (ex_branch_taken) begin
      // Squash both younger instructions in one cycle while fetching the target.
      ctrl.if_id_no_output = 1'b0;
      ctrl.id_ex_no_output = 1'b0;
      state_d              = ST_FLUSH;
    end else if (mdu_busy) begin
      ctrl.pc_en    = 1'b0;
      ctrl.if_id_en = 1'b0;
      ctrl.id_ex_en = 1'b0;
      state_d       = ST_BUSY;
    end else if (lu_hit && (state_q != ST_FLUSH)) begin
      // Hold PC and IF/ID, push a bubble into ID/EX. The ID instruction is a
      // bubble right after a flush, so its operands are not trusted then.
      ctrl.pc_en           = 1'b0;
      ctrl.if_id_en        = 1'b0;
      ctrl.id_ex_no_output = 1'b0;
      state_d              = ST_LSTALL;
    end

    // While in reset every stage holds cleared contents.
    if (!rst) ctrl = '0;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples its inputs from before the edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_RUN;
    else      state_q <= state_d;
  end

  hazard_perf_cnt #(
    .CNT_W  (CNT_W),
    .FLUSH_W(FLUSH_W)
  ) u_perf_cnt (
    .clk           (clk),
    .rst           (rst),
    .stall_i       (!ctrl.pc_en),
    .flush_i       (ex_branch_taken),
    .stall_cycles_o(stall_cycles),
    .flush_count_o (flush_count)
  );

  assign pc_en           = ctrl.pc_en;
  assign if_id_en        = ctrl.if_id_en;
  assign if_id_no_output = ctrl.if_id_no_output;
  assign id_ex_en        = ctrl.id_ex_en;
  assign id_ex_no_output = ctrl.id_ex_no_output;
  assign state_o         = state_q;

endmodule
